// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce an active-low push-button into a held level plus press/release strobes.
`timescale 1ns/1ps
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_C);
  localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_END = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_END = CW'(REPEAT_PERIOD - 1);
  localparam logic [2:0] IDLE            = 3'd0;
  localparam logic [2:0] CONFIRM_PRESS   = 3'd1;
  localparam logic [2:0] HELD            = 3'd2;
  localparam logic [2:0] REPEAT          = 3'd3;
  localparam logic [2:0] CONFIRM_RELEASE = 3'd4;
  logic [1:0]    sync_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, press_q, press_d, rel_q, rel_d;
  logic          key_s;
  assign key_s = sync_q[1];
  // Every branch that changes state also clears the shared counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s) state_d = CONFIRM_PRESS;
      end
      CONFIRM_PRESS:
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_END) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      HELD:
        if (key_s) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end else if (REPEAT_EN != 0 && cnt_q == RD_END) begin
          state_d = REPEAT;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      REPEAT:
        if (key_s) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == RP_END) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end
      CONFIRM_RELEASE:
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= state_d == HELD || state_d == REPEAT || state_d == CONFIRM_RELEASE;
      press_q   <= press_d;
      rel_q     <= rel_d;
    end
  end
  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of key_debounce with and without auto-repeat.
`timescale 1ns/1ps
module tb_key_debounce;
  typedef struct {
    logic key;
    int   n;
    int   p1, r1, e1, p2, r2, e2;
  } seg_t;
  logic clk = 1'b0, rst_n = 1'b1, key_n = 1'b1;
  logic p1, pp1, rp1, p2, pp2, rp2;
  int   checks = 0, errors = 0;
  int   pc1 = 0, rc1 = 0, pc2 = 0, rc2 = 0;
  bit   overlap = 1'b0;
  seg_t tbl [13];
  key_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .pressed(p1), .press_pulse(pp1), .release_pulse(rp1));
  key_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .pressed(p2), .press_pulse(pp2), .release_pulse(rp2));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    pc1 += int'(pp1);
    rc1 += int'(rp1);
    pc2 += int'(pp2);
    rc2 += int'(rp2);
    if ((pp1 && rp1) || (pp2 && rp2)) overlap = 1'b1;
  end
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  initial begin
    int b1, b2, b3, b4;
    tbl = '{
      '{1'b0,   3,  0, 0, 0, 0, 0, 0},
      '{1'b1,   2,  0, 0, 0, 0, 0, 0},
      '{1'b0,   2,  0, 0, 0, 0, 0, 0},
      '{1'b1,   3,  0, 0, 0, 0, 0, 0},
      '{1'b0,   1,  0, 0, 0, 0, 0, 0},
      '{1'b1,   2,  0, 0, 0, 0, 0, 0},
      '{1'b0,  10,  1, 0, 1, 1, 0, 1},
      '{1'b0,  10,  0, 0, 1, 0, 0, 1},
      '{1'b1,   2,  0, 0, 1, 0, 0, 1},
      '{1'b0,   2,  0, 0, 1, 0, 0, 1},
      '{1'b1,  10,  0, 1, 0, 0, 1, 0},
      '{1'b0, 100, 11, 0, 1, 1, 0, 1},
      '{1'b1,  10,  0, 1, 0, 0, 1, 0}
    };
    #2 rst_n = 1'b0;
    repeat (3) step;
    chk("reset pressed", p1, 0);
    chk("reset press_pulse", pp1, 0);
    chk("reset release_pulse", rp1, 0);
    chk("reset pressed norepeat", p2, 0);
    rst_n = 1'b1;
    repeat (3) step;
    // Clean press then held: k counts edges from the first low sample.
    key_n = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      step;
      chk($sformatf("hold press_pulse k=%0d", k), pp1,
          int'(k == 6 || (k >= 26 && (k - 26) % 8 == 0)));
      chk($sformatf("hold pressed k=%0d", k), p1, int'(k >= 6));
      chk($sformatf("hold press_pulse norepeat k=%0d", k), pp2, int'(k == 6));
      chk($sformatf("hold pressed norepeat k=%0d", k), p2, int'(k >= 6));
    end
    key_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step;
      chk($sformatf("rel release_pulse k=%0d", k), rp1, int'(k == 6));
      chk($sformatf("rel pressed k=%0d", k), p1, int'(k < 6));
      chk($sformatf("rel press_pulse k=%0d", k), pp1, 0);
      chk($sformatf("rel release_pulse norepeat k=%0d", k), rp2, int'(k == 6));
    end
    // Bounce sequences and the no-repeat variant as segment vectors.
    for (int i = 0; i < 13; i++) begin
      b1 = pc1; b2 = rc1; b3 = pc2; b4 = rc2;
      key_n = tbl[i].key;
      repeat (tbl[i].n) step;
      chk($sformatf("seg%0d press count", i), pc1 - b1, tbl[i].p1);
      chk($sformatf("seg%0d release count", i), rc1 - b2, tbl[i].r1);
      chk($sformatf("seg%0d pressed", i), p1, tbl[i].e1);
      chk($sformatf("seg%0d press count norepeat", i), pc2 - b3, tbl[i].p2);
      chk($sformatf("seg%0d release count norepeat", i), rc2 - b4, tbl[i].r2);
      chk($sformatf("seg%0d pressed norepeat", i), p2, tbl[i].e2);
    end
    // Reset while a repeat strobe is high, key kept low across reset.
    key_n = 1'b0;
    for (int k = 0; k < 27; k++) step;
    chk("pre-reset repeat strobe", pp1, 1);
    chk("pre-reset pressed", p1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset press_pulse", pp1, 0);
    chk("async reset pressed", p1, 0);
    chk("async reset release_pulse", rp1, 0);
    chk("async reset pressed norepeat", p2, 0);
    step;
    step;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step;
      chk($sformatf("post-reset press_pulse k=%0d", k), pp1, int'(k == 6));
      chk($sformatf("post-reset pressed k=%0d", k), p1, int'(k >= 6));
      chk($sformatf("post-reset release_pulse k=%0d", k), rp1, 0);
      chk($sformatf("post-reset press_pulse norepeat k=%0d", k), pp2, int'(k == 6));
    end
    chk("strobe overlap", int'(overlap), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
